// File: rtl/borrow_look_subtractor_seq_pkg.sv
// Shared constants for the nibble-serial borrow-lookahead subtractor.
package borrow_look_subtractor_seq_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/borrow_look_sub4.sv
// 4-bit borrow-lookahead subtractor: {bout4, d4} = a4 - b4 - bin.
// Borrows are formed in parallel from generate/propagate terms.
module borrow_look_sub4 (
    input  logic [3:0] a4,
    input  logic [3:0] b4,
    input  logic       bin,
    output logic [3:0] d4,
    output logic       bout4
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    // A bit generates a borrow when a=0,b=1; it passes an incoming borrow when a==b.
    assign g = ~a4 & b4;
    assign p = ~(a4 ^ b4);

    // Flattened lookahead equations, no ripple through c[i-1].
    assign c[0] = bin;
    assign c[1] = g[0] | (p[0] & bin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & bin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & bin);

    assign d4    = a4 ^ b4 ^ c[3:0];
    assign bout4 = c[4];

endmodule

// File: rtl/borrow_look_subtractor_seq.sv
// Sequential WIDTH-bit subtractor: diff = a - b - bin, one lookahead nibble
// per clock, LSB nibble first, valid/ready on both sides.
module borrow_look_subtractor_seq
    import borrow_look_subtractor_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int NNIB = WIDTH / NIBBLE_W;
    localparam int CW   = (NNIB > 1) ? $clog2(NNIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NNIB - 1);

    state_t           state, nxt;
    logic [WIDTH-1:0] a_r, b_r, diff_r;
    logic [CW-1:0]    cnt;
    logic             brw;
    logic             bout_r, ovf_r;
    logic [3:0]       a4, b4, d4;
    logic             bo4;
    logic             last;

    // Select the nibble currently being processed.
    assign a4   = a_r[NIBBLE_W*int'(cnt) +: NIBBLE_W];
    assign b4   = b_r[NIBBLE_W*int'(cnt) +: NIBBLE_W];
    assign last = (cnt == LAST);

    borrow_look_sub4 u_sub4 (
        .a4    (a4),
        .b4    (b4),
        .bin   (brw),
        .d4    (d4),
        .bout4 (bo4)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    // Next-state: accept only in IDLE, finish after the last nibble, release on out_ready.
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (in_valid) nxt = BUSY;
            BUSY:    if (last)     nxt = DONE;
            DONE:    if (out_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Handshake outputs are pure state decodes; no combinational input-to-ready path.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Operand capture and nibble-serial result accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r    <= '0;
            b_r    <= '0;
            diff_r <= '0;
            cnt    <= '0;
            brw    <= 1'b0;
            bout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_r <= a;
                    b_r <= b;
                    brw <= bin;
                    cnt <= '0;
                end
                BUSY: begin
                    diff_r[NIBBLE_W*int'(cnt) +: NIBBLE_W] <= d4;
                    brw <= bo4;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        bout_r <= bo4;
                        // d4[3] is the result MSB on the final nibble.
                        ovf_r  <= (a_r[WIDTH-1] != b_r[WIDTH-1]) && (d4[3] != a_r[WIDTH-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign diff = diff_r;
    assign bout = bout_r;
    assign ovf  = ovf_r;

endmodule

// File: tb/tb_borrow_look_subtractor_seq.sv
// Directed bench for borrow_look_subtractor_seq (WIDTH=16).
module tb_borrow_look_subtractor_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] a, b;
    logic        bin;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
    logic        out_valid;
    logic        out_ready;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    borrow_look_subtractor_seq #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive operands on a falling edge, handshake on the next rising edge,
    // return at the falling edge right after the handshake.
    task automatic issue(input logic [15:0] ta, input logic [15:0] tb_, input logic tbin, input string tag);
        @(negedge clk);
        a = ta; b = tb_; bin = tbin; in_valid = 1'b1;
        chk({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Called at the falling edge after the handshake edge T; expects out_valid after T+4.
    task automatic wait_res(input string tag, input logic [15:0] ed, input logic eb, input logic eo);
        int lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({tag, "_lat"},  lat,  4);
        chk({tag, "_diff"}, diff, ed);
        chk({tag, "_bout"}, bout, eb);
        chk({tag, "_ovf"},  ovf,  eo);
    endtask

    // Accept the result and confirm return to IDLE.
    task automatic release_res(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_ov_low"}, out_valid, 0);
        chk({tag, "_ir_hi"},  in_ready,  1);
    endtask

    initial begin
        rst_n = 1'b0; a = '0; b = '0; bin = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #12;
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_diff",      diff,      0);
        chk("rst_bout",      bout,      0);
        chk("rst_ovf",       ovf,       0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic
        issue(16'h0005, 16'h0003, 1'b0, "basic");
        wait_res("basic", 16'h0002, 1'b0, 1'b0);
        release_res("basic");

        // Borrow ripples through every nibble
        issue(16'h0000, 16'h0001, 1'b0, "ripple");
        wait_res("ripple", 16'hFFFF, 1'b1, 1'b0);
        release_res("ripple");

        // Signed overflow: most negative minus one
        issue(16'h8000, 16'h0001, 1'b0, "sovf");
        wait_res("sovf", 16'h7FFF, 1'b0, 1'b1);
        release_res("sovf");

        // Borrow-in on equal operands
        issue(16'h1234, 16'h1234, 1'b1, "bin");
        wait_res("bin", 16'hFFFF, 1'b1, 1'b0);
        release_res("bin");

        // Back-pressure: hold DONE while new operands are offered
        issue(16'h0005, 16'h0003, 1'b0, "bp");
        wait_res("bp", 16'h0002, 1'b0, 1'b0);
        a = 16'h00FF; b = 16'h000F; bin = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_hold_diff", diff,      16'h0002);
            chk("bp_hold_bout", bout,      0);
            chk("bp_hold_ovf",  ovf,       0);
            chk("bp_hold_ir",   in_ready,  0);
            chk("bp_hold_ov",   out_valid, 1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_ir_back", in_ready,  1);
        chk("bp_ov_low",  out_valid, 0);
        chk("bp_diff_kept", diff, 16'h0002);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_accepted", in_ready, 0);
        wait_res("bp_new", 16'h00F0, 1'b0, 1'b0);
        release_res("bp_new");

        // Reset during BUSY after two nibbles have been written
        issue(16'hFFFF, 16'h0001, 1'b0, "mrst");
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_in_ready",  in_ready,  1);
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_diff",      diff,      0);
        chk("mrst_bout",      bout,      0);
        chk("mrst_ovf",       ovf,       0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_ir_after", in_ready, 1);
        issue(16'h00FF, 16'h000F, 1'b0, "fresh");
        wait_res("fresh", 16'h00F0, 1'b0, 1'b0);
        release_res("fresh");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/borrow_look_subtractor_seq.md
Name: borrow_look_subtractor_seq

Overview:
- Sequential multi-word subtractor, the counterpart of the team's 4-bit carry-lookahead adder.
- Computes diff = a - b - bin on WIDTH-bit operands, one 4-bit borrow-lookahead nibble per clock, LSB nibble first.
- Valid/ready handshake on both input and output.
- Used by datapath blocks that need wide subtraction without a wide combinational borrow chain.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4.
- NNIB, WIDTH/4, number of nibble steps; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- a  input  WIDTH  minuend; sampled on input handshake.
- b  input  WIDTH  subtrahend; sampled on input handshake.
- bin  input  1  borrow-in; sampled on input handshake.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- diff  output  WIDTH  result a - b - bin (mod 2^WIDTH).
- bout  output  1  borrow-out from the MSB nibble (1 = unsigned underflow).
- ovf  output  1  signed overflow.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, diff=0, bout=0, ovf=0; internal operand registers, nibble counter and borrow register all 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - If in_valid && in_ready at a clk edge: register a, b and bin (bin goes into the borrow register), set counter=0, move to BUSY.
- BUSY:
  - in_ready=0, out_valid=0.
  - Each cycle, the nibble k=counter computes {b4, d4} = a[4k+3:4k] - b[4k+3:4k] - borrow.
  - Write d4 into diff[4k+3:4k], load borrow with b4, increment counter.
  - After the nibble counter==NNIB-1 is processed: bout=b4; ovf=(a[MSB]!=b[MSB]) && (diff[MSB]!=a[MSB]); move to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - diff, bout and ovf are held stable while out_ready=0.
  - When out_valid && out_ready at a clk edge, move to IDLE. out_valid is 0 and in_ready is 1 from the next cycle.
- Latency: with the input handshake at edge T, out_valid rises after edge T+NNIB (4 cycles for WIDTH=16). Throughput is one operation per NNIB+2 cycles minimum.
- No overlap: in_valid is ignored outside IDLE. There is no combinational in_ready/out_ready path; the block accepts only in IDLE.
- diff keeps the last result in IDLE until overwritten nibble by nibble in the next BUSY.
- Arithmetic: unsigned modular result. bout is borrow-out from the MSB nibble (1 when a < b+bin unsigned). ovf treats the operands as two's complement.
- Borrow-lookahead within a nibble: generate g_i = ~a_i & b_i; propagate p_i = ~(a_i ^ b_i). Borrows are computed in parallel, not rippled.
- Reset mid-operation (BUSY or DONE): the in-flight result is discarded immediately and all outputs take their reset values.
- out_ready asserted in IDLE or BUSY has no effect.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) and NIBBLE_W=4.
- One combinational sub-module, borrow_look_sub4: inputs a4, b4, bin; outputs d4, bout4.
- The top level holds the FSM, counter, operand/result registers and nibble mux.

Test Plan:
- Basic: a=16'h0005, b=16'h0003, bin=0, handshake at T → out_valid after T+4; diff=16'h0002, bout=0, ovf=0.
- Full borrow ripple: a=16'h0000, b=16'h0001, bin=0 → diff=16'hFFFF, bout=1, ovf=0.
- Signed overflow: a=16'h8000, b=16'h0001, bin=0 → diff=16'h7FFF, bout=0, ovf=1.
- Borrow-in: a=16'h1234, b=16'h1234, bin=1 → diff=16'hFFFF, bout=1, ovf=0.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands.
  - diff, bout and ovf stay stable; in_ready stays 0; the new operands are not accepted.
  - After out_ready=1, the new operands are accepted the cycle after in_ready returns to 1.
- Reset mid-BUSY: drop rst_n after the 2nd nibble → outputs go to reset values immediately (asynchronously); after release, in_ready=1, and a fresh op 16'h00FF-16'h000F gives diff=16'h00F0.
